// File: rtl/mem_access_stage.sv
// Memory-access stage: sequences scalar (32-bit) and vector (64-bit) loads
// and stores over one 32-bit synchronous RAM port, stalls upstream during
// multi-beat accesses and feeds the MEM/WB register (bubbles while stalled).
module mem_access_stage #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  input  logic              reqWrite,
  input  logic              reqVec,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       storeData,
  input  logic [63:0]       aluResult,
  input  logic [1:0]        wEnRegIn,
  input  logic [3:0]        rdIn,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output logic [31:0]       memWData,
  input  logic [31:0]       memRData,
  output logic              stall,
  output logic [1:0]        wEnRegOut,
  output logic [3:0]        rdOut,
  output logic [63:0]       writeData
);

  typedef enum logic [1:0] {
    IDLE,
    RD_HI,
    RD_WAIT,
    WR_HI
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       low_q, low_d;
  logic [1:0]        wen_q, wen_d;
  logic [3:0]        rd_q, rd_d;
  logic              vec_q, vec_d;

  // Second-beat address; wraps modulo 2^ADDR_W by construction.
  logic [ADDR_W-1:0] addr_next;
  assign addr_next = addr_q + ADDR_W'(1);

  // Next-state and request-latch logic; a request is only taken in IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    low_d   = low_q;
    wen_d   = wen_q;
    rd_d    = rd_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          addr_d = addr;
          hi_d   = storeData[63:32];
          wen_d  = wEnRegIn;
          rd_d   = rdIn;
          vec_d  = reqVec;
          if (reqWrite) begin
            state_d = reqVec ? WR_HI : IDLE;
          end else begin
            state_d = reqVec ? RD_HI : RD_WAIT;
          end
        end
      end
      RD_HI: begin
        low_d   = memRData;
        state_d = RD_WAIT;
      end
      RD_WAIT: state_d = IDLE;
      WR_HI:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hi_q    <= '0;
      low_q   <= '0;
      wen_q   <= '0;
      rd_q    <= '0;
      vec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      low_q   <= low_d;
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      vec_q   <= vec_d;
    end
  end

  // Output decode; everything defaults to zero so stalls emit bubbles and
  // idle RAM cycles carry no write data. Reset forces all outputs low at once.
  always_comb begin
    memAddr   = '0;
    memWe     = 1'b0;
    memWData  = '0;
    stall     = 1'b0;
    wEnRegOut = '0;
    rdOut     = '0;
    writeData = '0;
    case (state_q)
      IDLE: begin
        if (!reqValid) begin
          writeData = aluResult;
          wEnRegOut = wEnRegIn;
          rdOut     = rdIn;
        end else if (reqWrite) begin
          memWe    = 1'b1;
          memAddr  = addr;
          memWData = storeData[31:0];
          stall    = reqVec;
        end else begin
          memAddr = addr;
          stall   = 1'b1;
        end
      end
      RD_HI: begin
        memAddr = addr_next;
        stall   = 1'b1;
      end
      RD_WAIT: begin
        writeData = vec_q ? {memRData, low_q} : {32'h0, memRData};
        wEnRegOut = wen_q;
        rdOut     = rd_q;
      end
      WR_HI: begin
        memWe    = 1'b1;
        memAddr  = addr_next;
        memWData = hi_q;
      end
      default: ;
    endcase
    if (rst) begin
      memAddr   = '0;
      memWe     = 1'b0;
      memWData  = '0;
      stall     = 1'b0;
      wEnRegOut = '0;
      rdOut     = '0;
      writeData = '0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage with a behavioural synchronous RAM.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqWrite;
  logic        reqVec;
  logic [15:0] addr;
  logic [63:0] storeData;
  logic [63:0] aluResult;
  logic [1:0]  wEnRegIn;
  logic [3:0]  rdIn;
  logic [15:0] memAddr;
  logic        memWe;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        stall;
  logic [1:0]  wEnRegOut;
  logic [3:0]  rdOut;
  logic [63:0] writeData;

  int checks = 0;
  int errors = 0;
  int wrCount = 0;
  int wrBefore;

  logic [31:0] ram [0:65535];

  mem_access_stage #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqWrite(reqWrite), .reqVec(reqVec),
    .addr(addr), .storeData(storeData), .aluResult(aluResult),
    .wEnRegIn(wEnRegIn), .rdIn(rdIn),
    .memAddr(memAddr), .memWe(memWe), .memWData(memWData),
    .memRData(memRData), .stall(stall),
    .wEnRegOut(wEnRegOut), .rdOut(rdOut), .writeData(writeData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: write on memWe, otherwise read data next cycle.
  always @(posedge clk) begin
    if (memWe) begin
      ram[memAddr] <= memWData;
      wrCount = wrCount + 1;
    end else begin
      memRData <= ram[memAddr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
    ram[16'h0020] = 32'hCAFEBABE;
    rst = 1'b1;
    reqValid = 1'b0; reqWrite = 1'b0; reqVec = 1'b0;
    addr = '0; storeData = '0;
    aluResult = 64'h0123_4567_89AB_CDEF; wEnRegIn = 2'b01; rdIn = 4'd6;
    #2;
    check("rst_writeData", writeData, 64'h0);
    check("rst_wEn", {62'h0, wEnRegOut}, 64'h0);
    check("rst_rd", {60'h0, rdOut}, 64'h0);
    check("rst_stall", {63'h0, stall}, 64'h0);
    check("rst_memWe", {63'h0, memWe}, 64'h0);
    tick();
    tick();
    rst = 1'b0;

    // Pass-through
    aluResult = 64'hDEAD_BEEF_0123_4567; rdIn = 4'd5; wEnRegIn = 2'b01;
    #1;
    check("pt_writeData", writeData, 64'hDEAD_BEEF_0123_4567);
    check("pt_rd", {60'h0, rdOut}, 64'd5);
    check("pt_wEn", {62'h0, wEnRegOut}, 64'd1);
    check("pt_stall", {63'h0, stall}, 64'h0);
    check("pt_memWe", {63'h0, memWe}, 64'h0);
    tick();

    // Vector store 0x10
    reqValid = 1'b1; reqWrite = 1'b1; reqVec = 1'b1; addr = 16'h0010;
    storeData = 64'h1122_3344_5566_7788; wEnRegIn = 2'b11; rdIn = 4'd7;
    #1;
    check("vst0_stall", {63'h0, stall}, 64'd1);
    check("vst0_memWe", {63'h0, memWe}, 64'd1);
    check("vst0_memAddr", {48'h0, memAddr}, 64'h10);
    check("vst0_memWData", {32'h0, memWData}, 64'h5566_7788);
    check("vst0_wEn", {62'h0, wEnRegOut}, 64'h0);
    tick();
    check("vst1_stall", {63'h0, stall}, 64'h0);
    check("vst1_memWe", {63'h0, memWe}, 64'd1);
    check("vst1_memAddr", {48'h0, memAddr}, 64'h11);
    check("vst1_memWData", {32'h0, memWData}, 64'h1122_3344);
    check("vst1_wEn", {62'h0, wEnRegOut}, 64'h0);
    tick();
    check("vst_ram10", {32'h0, ram[16'h0010]}, 64'h5566_7788);
    check("vst_ram11", {32'h0, ram[16'h0011]}, 64'h1122_3344);

    // Vector load 0x10 to rd=3, followed back-to-back by scalar store 0x21
    reqWrite = 1'b0; reqVec = 1'b1; addr = 16'h0010; rdIn = 4'd3; wEnRegIn = 2'b01;
    #1;
    check("vld0_stall", {63'h0, stall}, 64'd1);
    check("vld0_memAddr", {48'h0, memAddr}, 64'h10);
    check("vld0_wEn", {62'h0, wEnRegOut}, 64'h0);
    check("vld0_memWe", {63'h0, memWe}, 64'h0);
    tick();
    check("vld1_stall", {63'h0, stall}, 64'd1);
    check("vld1_memAddr", {48'h0, memAddr}, 64'h11);
    check("vld1_wEn", {62'h0, wEnRegOut}, 64'h0);
    check("vld1_writeData", writeData, 64'h0);
    tick();
    check("vld2_stall", {63'h0, stall}, 64'h0);
    check("vld2_writeData", writeData, 64'h1122_3344_5566_7788);
    check("vld2_rd", {60'h0, rdOut}, 64'd3);
    check("vld2_wEn", {62'h0, wEnRegOut}, 64'd1);
    reqWrite = 1'b1; reqVec = 1'b0; addr = 16'h0021;
    storeData = 64'h9999_9999_AABB_CCDD; wEnRegIn = 2'b11; rdIn = 4'd9;
    #1;
    check("b2b_ignored_memWe", {63'h0, memWe}, 64'h0);
    check("b2b_hold_writeData", writeData, 64'h1122_3344_5566_7788);
    check("b2b_hold_rd", {60'h0, rdOut}, 64'd3);
    tick();
    wrBefore = wrCount;
    check("sst_memWe", {63'h0, memWe}, 64'd1);
    check("sst_memAddr", {48'h0, memAddr}, 64'h21);
    check("sst_memWData", {32'h0, memWData}, 64'hAABB_CCDD);
    check("sst_stall", {63'h0, stall}, 64'h0);
    check("sst_wEn", {62'h0, wEnRegOut}, 64'h0);
    tick();
    reqValid = 1'b0; aluResult = 64'h5; wEnRegIn = 2'b00; rdIn = 4'd0;
    #1;
    check("sst_ram21", {32'h0, ram[16'h0021]}, 64'hAABB_CCDD);
    check("sst_one_write", 64'(wrCount - wrBefore), 64'd1);
    check("sst_after_memWe", {63'h0, memWe}, 64'h0);
    tick();

    // Scalar load 0x20
    reqValid = 1'b1; reqWrite = 1'b0; reqVec = 1'b0; addr = 16'h0020;
    rdIn = 4'd4; wEnRegIn = 2'b10;
    #1;
    check("sld0_stall", {63'h0, stall}, 64'd1);
    check("sld0_memAddr", {48'h0, memAddr}, 64'h20);
    check("sld0_wEn", {62'h0, wEnRegOut}, 64'h0);
    tick();
    check("sld1_stall", {63'h0, stall}, 64'h0);
    check("sld1_writeData", writeData, 64'h0000_0000_CAFE_BABE);
    check("sld1_rd", {60'h0, rdOut}, 64'd4);
    check("sld1_wEn", {62'h0, wEnRegOut}, 64'd2);
    reqValid = 1'b0;
    tick();

    // Wrap-around vector store at 0xFFFF
    reqValid = 1'b1; reqWrite = 1'b1; reqVec = 1'b1; addr = 16'hFFFF;
    storeData = 64'hAAAA_0000_BBBB_1111;
    #1;
    check("wrap0_memAddr", {48'h0, memAddr}, 64'hFFFF);
    check("wrap0_memWData", {32'h0, memWData}, 64'hBBBB_1111);
    tick();
    check("wrap1_memAddr", {48'h0, memAddr}, 64'h0000);
    check("wrap1_memWData", {32'h0, memWData}, 64'hAAAA_0000);
    check("wrap1_memWe", {63'h0, memWe}, 64'd1);
    reqValid = 1'b0;
    tick();
    check("wrap_ramFFFF", {32'h0, ram[16'hFFFF]}, 64'hBBBB_1111);
    check("wrap_ram0000", {32'h0, ram[16'h0000]}, 64'hAAAA_0000);

    // Reset in the RD_HI cycle of a vector load
    reqValid = 1'b1; reqWrite = 1'b0; reqVec = 1'b1; addr = 16'h0010;
    rdIn = 4'd2; wEnRegIn = 2'b01;
    tick();
    check("rstmid_pre_stall", {63'h0, stall}, 64'd1);
    rst = 1'b1;
    reqValid = 1'b0; aluResult = 64'h7777_6666_5555_4444; rdIn = 4'd8; wEnRegIn = 2'b11;
    #1;
    check("rstmid_stall", {63'h0, stall}, 64'h0);
    check("rstmid_memAddr", {48'h0, memAddr}, 64'h0);
    check("rstmid_writeData", writeData, 64'h0);
    check("rstmid_wEn", {62'h0, wEnRegOut}, 64'h0);
    check("rstmid_rd", {60'h0, rdOut}, 64'h0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_writeData", writeData, 64'h7777_6666_5555_4444);
    check("post_rst_wEn", {62'h0, wEnRegOut}, 64'd3);
    check("post_rst_rd", {60'h0, rdOut}, 64'd8);
    check("post_rst_stall", {63'h0, stall}, 64'h0);
    tick();
    tick();
    check("post_rst_writeData2", writeData, 64'h7777_6666_5555_4444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
